// File: rtl/slot_drain.sv
// Slot drain: NSLOT value slots (zero = empty) emptied one at a time through a valid/ready port.
// Define SLOT_DRAIN_RR_EN for round-robin slot selection; the default build uses fixed lowest-index priority.
module slot_drain #(
    parameter int DW    = 8,
    parameter int NSLOT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSLOT-1:0]    slot_wr_en,
    input  logic [NSLOT*DW-1:0] slot_wr_data,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [1:0]          out_slot,
    input  logic                out_ready,
    output logic [NSLOT-1:0]    slot_free,
    output logic                wr_err,
    output logic [15:0]         drain_cnt
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    logic              state;
    logic [DW-1:0]     slots [NSLOT];
    logic [DW-1:0]     wdata [NSLOT];
    logic [NSLOT-1:0]  occ;
    logic [NSLOT-1:0]  wr_nz;
    logic [NSLOT-1:0]  wr_ok;
    logic              wr_hit;
    logic              any_occ;
    logic              handshake;
    logic [1:0]        pick;
`ifdef SLOT_DRAIN_RR_EN
    logic [1:0]        last;
    logic              found;
    int                idx;
`endif

    // Occupancy and write legality are judged on pre-edge slot contents only.
    always_comb begin
        occ   = '0;
        wr_nz = '0;
        wr_ok = '0;
        for (int i = 0; i < NSLOT; i++) begin
            wdata[i] = slot_wr_data[i*DW +: DW];
            occ[i]   = (slots[i] != '0);
            wr_nz[i] = slot_wr_en[i] && (wdata[i] != '0);
            wr_ok[i] = wr_nz[i] && !occ[i];
        end
        wr_hit    = |(wr_nz & occ);
        any_occ   = |occ;
        handshake = (state == ST_PRESENT) && out_ready;
    end

`ifdef SLOT_DRAIN_RR_EN
    // Search starts just past the most recently drained slot and wraps around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NSLOT; k++) begin
            idx = (int'(last) + k) % NSLOT;
            if (!found && occ[idx]) begin
                pick  = idx[1:0];
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (occ[i]) pick = 2'(i);
        end
    end
`endif

    assign out_valid = (state == ST_PRESENT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) slots[i] <= '0;
            state     <= ST_IDLE;
            out_data  <= '0;
            out_slot  <= '0;
            drain_cnt <= '0;
            wr_err    <= 1'b0;
            slot_free <= '1;
`ifdef SLOT_DRAIN_RR_EN
            last      <= 2'(NSLOT - 1);
`endif
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (wr_ok[i]) slots[i] <= wdata[i];
            end
            wr_err    <= wr_hit;
            slot_free <= ~occ;
            case (state)
                ST_IDLE: begin
                    if (any_occ) begin
                        out_data <= slots[pick];
                        out_slot <= pick;
                        state    <= ST_PRESENT;
                    end
                end
                default: begin
                    // The presented slot is occupied, so no same-edge write can target it.
                    if (handshake) begin
                        slots[out_slot] <= '0;
                        drain_cnt       <= drain_cnt + 16'd1;
                        state           <= ST_IDLE;
`ifdef SLOT_DRAIN_RR_EN
                        last            <= out_slot;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slot_drain.sv
// Directed self-checking bench for slot_drain with a scoreboard of expected drains.
module tb_slot_drain;

    logic        clk;
    logic        rst;
    logic [2:0]  slot_wr_en;
    logic [23:0] slot_wr_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_slot;
    logic        out_ready;
    logic [2:0]  slot_free;
    logic        wr_err;
    logic [15:0] drain_cnt;

    typedef struct {
        logic [1:0] slot;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    slot_drain #(.DW(8), .NSLOT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .slot_wr_en   (slot_wr_en),
        .slot_wr_data (slot_wr_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_slot     (out_slot),
        .out_ready    (out_ready),
        .slot_free    (slot_free),
        .wr_err       (wr_err),
        .drain_cnt    (drain_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expectDrain(input logic [1:0] slot, input logic [7:0] data);
        exp_t e;
        e.slot = slot;
        e.data = data;
        sb.push_back(e);
    endtask

    // Advance one edge; a handshake pending at that edge is scored first.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_drain", 32'(out_slot), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                checkOutput("drain_slot", 32'(out_slot), 32'(e.slot));
                checkOutput("drain_data", 32'(out_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] en, input logic [23:0] data);
        slot_wr_en   = en;
        slot_wr_data = data;
        step();
        slot_wr_en   = '0;
        slot_wr_data = '0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_free"},  32'(slot_free), 32'd7);
        checkOutput({tag, "_err"},   32'(wr_err),    32'd0);
        checkOutput({tag, "_cnt"},   32'(drain_cnt), 32'd0);
        checkOutput({tag, "_data"},  32'(out_data),  32'd0);
        checkOutput({tag, "_slot"},  32'(out_slot),  32'd0);
    endtask

    initial begin
        logic [7:0] pattern;
        rst          = 1'b1;
        slot_wr_en   = '0;
        slot_wr_data = '0;
        out_ready    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkReset("reset");
        rst = 1'b0;

        // Three slots written together drain in index order every other cycle.
        out_ready = 1'b1;
        expectDrain(2'd0, 8'd13);
        expectDrain(2'd1, 8'd14);
        expectDrain(2'd2, 8'd15);
        applyStimulus(3'b111, {8'd15, 8'd14, 8'd13});
        checkOutput("burst_valid_after_write", 32'(out_valid), 32'd0);
        pattern = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            pattern[i] = out_valid;
        end
        checkOutput("burst_valid_pattern", 32'(pattern), 32'b010101);
        checkOutput("burst_cnt", 32'(drain_cnt), 32'd3);
        step();
        checkOutput("burst_free", 32'(slot_free), 32'd7);

        // Backpressure: presentation of slot 1 stays frozen while out_ready is low.
        out_ready = 1'b0;
        expectDrain(2'd1, 8'd20);
        applyStimulus(3'b010, {8'd0, 8'd20, 8'd0});
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data",  32'(out_data),  32'd20);
            checkOutput("hold_slot",  32'(out_slot),  32'd1);
            step();
        end
        checkOutput("hold_free_busy", 32'(slot_free[1]), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("hold_valid_after_hs", 32'(out_valid), 32'd0);
        step();
        checkOutput("hold_free_after_hs", 32'(slot_free[1]), 32'd1);

        // A write onto an occupied slot is dropped and flagged.
        expectDrain(2'd0, 8'd7);
        applyStimulus(3'b001, {8'd0, 8'd0, 8'd7});
        applyStimulus(3'b001, {8'd0, 8'd0, 8'd9});
        checkOutput("err_pulse", 32'(wr_err), 32'd1);
        checkOutput("err_present_data", 32'(out_data), 32'd7);
        step();
        checkOutput("err_pulse_end", 32'(wr_err), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("err_cnt", 32'(drain_cnt), 32'd5);

        // Zero-valued write is a no-op.
        applyStimulus(3'b010, 24'd0);
        checkOutput("zero_err", 32'(wr_err), 32'd0);
        checkOutput("zero_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("zero_free", 32'(slot_free), 32'd7);
        checkOutput("zero_valid_later", 32'(out_valid), 32'd0);

        // Slots 0 and 2 waiting while slot 1 drains: the policy decides who goes next.
        expectDrain(2'd1, 8'd20);
`ifdef SLOT_DRAIN_RR_EN
        expectDrain(2'd2, 8'd8);
        expectDrain(2'd0, 8'd5);
`else
        expectDrain(2'd0, 8'd5);
        expectDrain(2'd2, 8'd8);
`endif
        applyStimulus(3'b010, {8'd0, 8'd20, 8'd0});
        step();
        applyStimulus(3'b101, {8'd8, 8'd0, 8'd5});
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
        checkOutput("policy_cnt", 32'(drain_cnt), 32'd8);
        checkOutput("policy_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during a presentation with out_ready high aborts it; writes under reset are ignored.
        applyStimulus(3'b100, {8'd8, 8'd0, 8'd0});
        step();
        checkOutput("abort_presenting", 32'(out_valid), 32'd1);
        rst          = 1'b1;
        out_ready    = 1'b1;
        slot_wr_en   = 3'b001;
        slot_wr_data = {8'd0, 8'd0, 8'd9};
        @(posedge clk);
        #1;
        checkReset("abort");
        slot_wr_en   = '0;
        slot_wr_data = '0;
        rst          = 1'b0;
        step();
        step();
        checkOutput("post_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("post_reset_free",  32'(slot_free), 32'd7);
        checkOutput("post_reset_cnt",   32'(drain_cnt), 32'd0);
        checkOutput("final_sb_empty",   32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_drain.md
SLOT_DRAIN -- requirements
Module: slot_drain

Interface
REQ-001 Parameter DW, default 8, width of each slot value.
REQ-002 Parameter NSLOT, default 3, number of slots.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 slot_wr_en  input  NSLOT  per-slot write strobe from the slot allocator.
REQ-006 slot_wr_data  input  NSLOT*DW  per-slot write value, slot i at bits [i*DW +: DW].
REQ-007 out_valid  output  1  a drained value is presented.
REQ-008 out_data  output  DW  drained slot value.
REQ-009 out_slot  output  2  index of the slot being drained.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 slot_free  output  NSLOT  bit i high when slot i is empty, registered.
REQ-012 wr_err  output  1  one-cycle pulse when a write hits an occupied slot.
REQ-013 drain_cnt  output  16  count of completed handshakes, wraps at 16'hFFFF to 0.

Function
REQ-014 A slot value of zero SHALL mean empty; slot i is occupied iff its stored value is nonzero.
REQ-015 slot_wr_en[i] with a nonzero value and slot i empty at the edge SHALL store the value.
REQ-016 slot_wr_en[i] with zero data SHALL be ignored, with no wr_err.
REQ-017 slot_wr_en[i] with nonzero data and slot i occupied at the edge SHALL drop the write and pulse wr_err the next cycle.
REQ-018 The occupancy test SHALL use pre-edge state, including the slot being drained that same cycle.
REQ-019 FSM states SHALL be IDLE and PRESENT.
REQ-020 IDLE: out_valid=0. If any slot is occupied, select one, latch out_data and out_slot, and go to PRESENT.
REQ-021 PRESENT: out_valid=1, with out_data and out_slot held stable until out_valid && out_ready.
REQ-022 On a handshake in PRESENT, the selected slot SHALL be cleared to zero and drain_cnt incremented on the same edge.
REQ-023 The next state after a handshake SHALL be IDLE; back-to-back presentations therefore have a one-cycle gap.
REQ-024 Latency: a slot written at edge N SHALL give out_valid=1 at edge N+1 at earliest.
REQ-025 slot_free SHALL equal ~occupancy, registered, so it reflects a write or clear one cycle after the edge.
REQ-026 Multiple slot_wr_en bits SHALL be handled independently in one cycle; wr_err pulses if any single write errs.
REQ-027 Throughput: at most one value drained per two cycles.

Reset
REQ-028 While rst=1, all slots, drain_cnt, out_data and out_slot SHALL be 0, out_valid=0, wr_err=0, slot_free=all ones, and the FSM in IDLE.
REQ-029 Reset asserted in PRESENT SHALL abort the presentation; the value is lost and drain_cnt is not incremented.
REQ-030 Writes during reset SHALL be ignored.

Configuration
REQ-031 Macro SLOT_DRAIN_RR_EN defined: selection SHALL be round-robin, starting after the last drained index (pointer resets to slot NSLOT-1, so slot 0 is first).
REQ-032 SLOT_DRAIN_RR_EN undefined: selection SHALL be fixed priority, lowest occupied index first.

Verification
REQ-033 Write slots 0,1,2 = 13,14,15 in one cycle, out_ready=1 -> drained in slot order 0,1,2 with data 13,14,15, out_valid high every other cycle, drain_cnt=3, slot_free=3'b111.
REQ-034 Slot 1 = 20, out_ready=0 for 5 cycles -> out_valid, out_data=20 and out_slot=1 held stable; raise out_ready -> slot_free[1]=1 the next cycle.
REQ-035 Slot 0 occupied with 7, write slot 0 = 9 -> wr_err pulses one cycle and the value drained is 7.
REQ-036 slot_wr_en=3'b010 with data 0 -> no state change, wr_err=0, out_valid stays 0.
REQ-037 With SLOT_DRAIN_RR_EN, keep slot 0 refilled with 5 and slot 2 holding 8 -> drained slots alternate 0,2,0,2; without the macro, slot 0 is always drained and slot 2 starves.
REQ-038 Assert rst in PRESENT with out_ready=1 on the same cycle -> after reset all outputs are at reset values and drain_cnt=0.
